seg_scan_display: RTL and testbench

Parametrised, time-multiplexed hex display driver for multi-digit common-anode seven-segment modules. It holds a shadow copy of up to DIGITS hex nibbles, scans one digit per slot, and drives a shared active-low segment bus plus active-low digit anodes. Per-digit enables, decimal points, leading-zero suppression and inter-digit blanking against ghosting are also provided. It sits between the datapath/debug registers and the board display pins.

---
 rtl/seg_scan_display.sv | 146 ++++++++++++++
 tb/tb_seg_scan_display.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed hex driver for common-anode 7-segment modules.
// Holds shadow copies of the digit nibbles, decimal points and enables, then scans
// one digit per SCAN_DIV-cycle slot. The first BLANK_CYC cycles of each slot keep
// every anode off to suppress ghosting.
// Ports:
//   clk, rst     - clock (rising edge), synchronous active-high reset
//   data         - DIGITS hex nibbles; nibble i = data[4i+3:4i]
//   dp_in        - decimal point request per digit (1 = lit)
//   digit_en     - per-digit enable (0 = always dark)
//   load         - capture data/dp_in/digit_en into the shadow registers
//   lz_suppress  - level; blanks leading zero digits (digit 0 always shown)
//   SEG          - active-low segments, [7]=dp, [6:0]=g..a (registered)
//   AN           - active-low anodes, at most one low (registered)
//   frame_done   - one-cycle pulse after each full scan of all digits (registered)
module seg_scan_display #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  input  logic                  lz_suppress,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_en;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_en;
  logic                cur_supp;
  logic                zero_run;
  logic                blank_c;
  logic [7:0]          seg_c;
  logic [DIGITS-1:0]   an_c;
  logic                wrap_c;

  // Hex nibble to active-low g..a pattern.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Shadow registers; reset wins over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
    end else if (load) begin
      sh_data <= data;
      sh_dp   <= dp_in;
      sh_en   <= digit_en;
    end
  end

  // Slot prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Select the current digit and evaluate leading-zero suppression from the top down.
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_en   = 1'b0;
    cur_supp = 1'b0;
    zero_run = lz_suppress;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run && (sh_data[4*i +: 4] == 4'h0) && !sh_dp[i];
      if (idx == IDX_W'(i)) begin
        cur_nib  = sh_data[4*i +: 4];
        cur_dp   = sh_dp[i];
        cur_en   = sh_en[i];
        cur_supp = zero_run && (i != 0);
      end
    end
  end

  // Next slot output, built from pre-edge counter and shadow state.
  always_comb begin
    blank_c = (32'(cnt) < 32'(BLANK_CYC)) || !cur_en || cur_supp;
    seg_c   = 8'hFF;
    an_c    = '1;
    if (!blank_c) begin
      seg_c = {~cur_dp, hex7(cur_nib)};
      an_c  = ~(DIGITS'(1) << idx);
    end
    wrap_c = (cnt == CNT_LAST) && (idx == IDX_LAST);
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      SEG        <= 8'hFF;
      AN         <= '1;
      frame_done <= 1'b0;
    end else begin
      SEG        <= seg_c;
      AN         <= an_c;
      frame_done <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display.
// Main instance: DIGITS=4, SCAN_DIV=4, BLANK_CYC=1. Decode instance: DIGITS=1, SCAN_DIV=2, BLANK_CYC=0.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;
  logic        lz = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        fd;

  logic [3:0]  d1_data = '0;
  logic        d1_dp = 1'b0;
  logic        d1_en = 1'b0;
  logic        d1_load = 1'b0;
  logic        d1_lz = 1'b0;
  logic [7:0]  seg1;
  logic        an1;
  logic        fd1;

  int tests = 0;
  int fails = 0;
  int n = 0;

  always #5 clk = ~clk;

  seg_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .lz_suppress(lz), .SEG(seg), .AN(an), .frame_done(fd)
  );

  seg_scan_display #(.DIGITS(1), .SCAN_DIV(2), .BLANK_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .data(d1_data), .dp_in(d1_dp), .digit_en(d1_en),
    .load(d1_load), .lz_suppress(d1_lz), .SEG(seg1), .AN(an1), .frame_done(fd1)
  );

  // Hand-written segment table (active-low g..a).
  function automatic logic [6:0] code7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h18; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Expected {SEG, AN} after edge n counted from the load edge (n=0), 4-digit instance.
  function automatic logic [11:0] exp_main(input int k, input logic [15:0] dat,
                                           input logic [3:0] dp, input logic [3:0] en,
                                           input logic lzv);
    int c;
    int d;
    logic z;
    logic [3:0] nib;
    logic [3:0] anv;
    c = k % 4;
    d = (k / 4) % 4;
    z = lzv;
    for (int j = 3; j >= d; j--) z = z && (dat[4*j +: 4] == 4'h0) && !dp[j];
    if (c == 0 || !en[d] || (z && d > 0)) return {8'hFF, 4'hF};
    nib = dat[4*d +: 4];
    anv = 4'b1 << d;
    return {~dp[d], code7(nib), ~anv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      n++;
    end
  endtask

  // Reset, then load at the first post-release edge (E0, n=0).
  task automatic start_run(input logic [15:0] dv, input logic [3:0] dpv, input logic [3:0] env);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    data = dv; dp_in = dpv; digit_en = env; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    load = 1'b1; data = 16'hFFFF; dp_in = 4'hF; digit_en = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (seg !== 8'hFF || an !== 4'hF || fd !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: SEG=%h AN=%h fd=%b want FF F 0", i, seg, an, fd);
      end
    end
    rst = 1'b0; load = 1'b0;
    tick();
    tests++;
    if (seg !== 8'hFF || an !== 4'hF || fd !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_edge: SEG=%h AN=%h fd=%b want FF F 0", seg, an, fd);
    end
    tick();
    tests++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      fails++;
      $display("FAIL reset_over_load: SEG=%h AN=%h want FF F", seg, an);
    end
  endtask

  task automatic test_scan();
    logic [11:0] e;
    start_run(16'h3210, 4'h0, 4'hF);
    tests++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      fails++;
      $display("FAIL scan_e0: SEG=%h AN=%h want FF F", seg, an);
    end
    for (int k = 1; k <= 32; k++) begin
      adv(1);
      e = exp_main(n, 16'h3210, 4'h0, 4'hF, 1'b0);
      tests++;
      if ({seg, an} !== e || fd !== (n % 16 == 15)) begin
        fails++;
        $display("FAIL scan n=%0d: SEG=%h AN=%h fd=%b want %h %h %b",
                 n, seg, an, fd, e[11:4], e[3:0], (n % 16 == 15));
      end
    end
  endtask

  task automatic test_decode();
    int pulses;
    d1_en = 1'b1;
    for (int dpb = 0; dpb < 2; dpb++) begin
      for (int v = 0; v < 16; v++) begin
        d1_data = 4'(v); d1_dp = 1'(dpb); d1_load = 1'b1;
        tick();
        d1_load = 1'b0;
        tick();
        tests++;
        if (seg1 !== {~d1_dp, code7(4'(v))} || an1 !== 1'b0) begin
          fails++;
          $display("FAIL decode v=%h dp=%0d: SEG=%h AN=%b want %h 0",
                   v, dpb, seg1, an1, {~d1_dp, code7(4'(v))});
        end
      end
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fd1 === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 2) begin
      fails++;
      $display("FAIL decode_frame_done: pulses=%0d want 2", pulses);
    end
  endtask

  task automatic test_lz();
    lz = 1'b1;
    start_run(16'h0050, 4'h0, 4'hF);
    adv(2);
    tests++;
    if (seg !== 8'hC0 || an !== 4'hE) begin
      fails++; $display("FAIL lz_d0: SEG=%h AN=%h want C0 E", seg, an);
    end
    adv(4);
    tests++;
    if (seg !== 8'h92 || an !== 4'hD) begin
      fails++; $display("FAIL lz_d1: SEG=%h AN=%h want 92 D", seg, an);
    end
    adv(4);
    tests++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      fails++; $display("FAIL lz_d2: SEG=%h AN=%h want FF F", seg, an);
    end
    adv(4);
    tests++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      fails++; $display("FAIL lz_d3: SEG=%h AN=%h want FF F", seg, an);
    end
    dp_in = 4'b0100; load = 1'b1;
    adv(1);
    load = 1'b0;
    adv(11);
    tests++;
    if (seg !== 8'h40 || an !== 4'hB) begin
      fails++; $display("FAIL lz_d2_dp: SEG=%h AN=%h want 40 B", seg, an);
    end
    adv(4);
    tests++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      fails++; $display("FAIL lz_d3_dp: SEG=%h AN=%h want FF F", seg, an);
    end
    lz = 1'b0;
    adv(1);
    tests++;
    if (seg !== 8'hC0 || an !== 4'h7) begin
      fails++; $display("FAIL lz_off: SEG=%h AN=%h want C0 7", seg, an);
    end
  endtask

  task automatic test_enable();
    logic [11:0] e;
    start_run(16'h3210, 4'h0, 4'b1010);
    for (int k = 1; k <= 32; k++) begin
      adv(1);
      e = exp_main(n, 16'h3210, 4'h0, 4'b1010, 1'b0);
      tests++;
      if ({seg, an} !== e || fd !== (n % 16 == 15)) begin
        fails++;
        $display("FAIL enable n=%0d: SEG=%h AN=%h fd=%b want %h %h %b",
                 n, seg, an, fd, e[11:4], e[3:0], (n % 16 == 15));
      end
    end
  endtask

  task automatic test_midop();
    start_run(16'h3210, 4'h0, 4'hF);
    adv(5);
    data = 16'hFFFF; load = 1'b1;
    adv(1);
    load = 1'b0;
    tests++;
    if (seg !== 8'hF9 || an !== 4'hD) begin
      fails++; $display("FAIL midop_load_edge: SEG=%h AN=%h want F9 D", seg, an);
    end
    adv(1);
    tests++;
    if (seg !== 8'h8E || an !== 4'hD) begin
      fails++; $display("FAIL midop_load_visible: SEG=%h AN=%h want 8E D", seg, an);
    end
    adv(3);
    tests++;
    if (seg !== 8'h8E || an !== 4'hB) begin
      fails++; $display("FAIL midop_d2: SEG=%h AN=%h want 8E B", seg, an);
    end
    rst = 1'b1;
    adv(1);
    tests++;
    if (seg !== 8'hFF || an !== 4'hF || fd !== 1'b0) begin
      fails++; $display("FAIL midop_rst: SEG=%h AN=%h fd=%b want FF F 0", seg, an, fd);
    end
    rst = 1'b0; data = 16'h3210; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    adv(1);
    tests++;
    if (seg !== 8'hC0 || an !== 4'hE) begin
      fails++; $display("FAIL midop_restart_d0: SEG=%h AN=%h want C0 E", seg, an);
    end
    adv(4);
    tests++;
    if (seg !== 8'hF9 || an !== 4'hD) begin
      fails++; $display("FAIL midop_restart_d1: SEG=%h AN=%h want F9 D", seg, an);
    end
    adv(9);
    tests++;
    if (fd !== 1'b0) begin
      fails++; $display("FAIL midop_fd_early: fd=%b want 0", fd);
    end
    adv(1);
    tests++;
    if (fd !== 1'b1) begin
      fails++; $display("FAIL midop_fd_wrap: fd=%b want 1", fd);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_lz();
    test_enable();
    test_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
